// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - Fetch-stage bus: instruction memory port, redirect input and IF/ID handshake
// master = fetch_unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        fetch_done;
  logic        fetch_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_target,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc_plus4,
    output fetch_done,
    output fetch_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_target,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus4,
    input  fetch_done,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 instruction-fetch stage: PC, imem address and IF/ID register
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirects trap into a sticky FAULT state.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] ADDR_LIMIT = 32'd128
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_RUN, S_DONE, S_FAULT} state_e;
`else
  typedef enum logic [0:0] {S_RUN, S_DONE} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] plus4_q, plus4_d;

  logic        load;
  logic        in_fault;
  logic [31:0] pc_next;
  logic [31:0] tgt_aligned;

  assign load        = !valid_q || bus.id_ready;
  assign pc_next     = pc_q + 32'd4;
  assign tgt_aligned = bus.redirect_target & 32'hFFFF_FFFC;

`ifdef FETCH_ALIGN_CHECK_EN
  assign in_fault = (state_q == S_FAULT);
`else
  assign in_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    id_pc_d = id_pc_q;
    plus4_d = plus4_q;
    // Redirect flushes IF/ID and discards any capture of this cycle.
    if (bus.redirect_valid && !in_fault) begin
      valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (bus.redirect_target[1:0] != 2'b00) begin
        state_d = S_FAULT;
      end else begin
`endif
        pc_d    = tgt_aligned;
        state_d = (tgt_aligned < ADDR_LIMIT) ? S_RUN : S_DONE;
`ifdef FETCH_ALIGN_CHECK_EN
      end
`endif
    end else begin
      case (state_q)
        S_RUN: begin
          if (load) begin
            instr_d = bus.imem_data;
            id_pc_d = pc_q;
            plus4_d = pc_next;
            valid_d = 1'b1;
            pc_d    = pc_next;
            if (pc_next >= ADDR_LIMIT) state_d = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.id_ready) valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      id_pc_q <= 32'd0;
      plus4_q <= 32'd4;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      id_pc_q <= id_pc_d;
      plus4_q <= plus4_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_instr    = instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = plus4_q;
  assign bus.fetch_done  = (state_q == S_DONE);
  assign bus.fetch_fault = in_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - Scoreboard bench for fetch_unit: directed cases plus random stalls/redirects
// Expected stream: every redirect/reset restarts the in-order PC sequence from target up to ADDR_LIMIT.
module tb_fetch_unit;
  localparam logic [31:0] LIMIT = 32'd128;

  logic clk;
  logic reset;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'd0), .ADDR_LIMIT(LIMIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [31:0] mem [64];
  assign bus.imem_data = mem[bus.imem_addr[7:2]];

  logic [31:0] exp_q [$];
  logic [31:0] mon_pc;
  int errors = 0;
  int checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // The instruction stream decode should see after a restart at byte address t.
  task automatic push_stream(input logic [31:0] t);
    logic [31:0] a;
    exp_q.delete();
    a = t & 32'hFFFF_FFFC;
    while (a < LIMIT) begin
      exp_q.push_back(a);
      a += 32'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pc(input logic [31:0] p);
    int n;
    n = 0;
    while (bus.id_pc !== p && n < 30) begin
      step();
      n++;
    end
    chk("wait_pc", bus.id_pc, p);
  endtask

  always @(negedge clk) begin
    if (!reset && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_instr: got id_pc=%h expected no instruction", bus.id_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        chk("stream_pc", bus.id_pc, mon_pc);
        chk("stream_instr", bus.id_instr, mem[mon_pc[7:2]]);
        chk("stream_pc_plus4", bus.id_pc_plus4, mon_pc + 32'd4);
      end
    end
  end

  initial begin
    int n;
    logic        rv;
    logic [31:0] rt;

    for (int i = 0; i < 64; i++) mem[i] = (i % 5 == 3) ? 32'd0 : $urandom;
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0010_1083;

    reset = 1'b0;
    bus.id_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_target = 32'd0;
    #1 reset = 1'b1;
    #1;
    chkb("rst_id_valid", bus.id_valid, 1'b0);
    chk("rst_id_instr", bus.id_instr, 32'd0);
    chk("rst_id_pc", bus.id_pc, 32'd0);
    chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'd4);
    chk("rst_imem_addr", bus.imem_addr, 32'd0);
    chkb("rst_fetch_done", bus.fetch_done, 1'b0);
    chkb("rst_fetch_fault", bus.fetch_fault, 1'b0);
    push_stream(32'd0);

    step();
    reset = 1'b0;
    step();
    chkb("edge1_valid", bus.id_valid, 1'b1);
    chk("edge1_pc", bus.id_pc, 32'd0);
    chk("edge1_instr", bus.id_instr, 32'd0);
    step();
    chk("edge2_pc", bus.id_pc, 32'd4);
    chk("edge2_instr", bus.id_instr, 32'h0010_1083);
    chk("edge2_plus4", bus.id_pc_plus4, 32'd8);

    // stall while id_pc = 8
    step();
    chk("pre_stall_pc", bus.id_pc, 32'd8);
    bus.id_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_id_pc", bus.id_pc, 32'd8);
      chk("stall_imem_addr", bus.imem_addr, 32'd12);
    end
    bus.id_ready = 1'b1;
    step();
    chk("release_pc0", bus.id_pc, 32'd12);
    step();
    chk("release_pc1", bus.id_pc, 32'd16);

    // redirect to 44 while id_pc = 36
    wait_pc(32'd36);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd44;
    step();
    bus.redirect_valid = 1'b0;
    push_stream(32'd44);
    chkb("redir_bubble", bus.id_valid, 1'b0);
    step();
    chk("redir_target_pc", bus.id_pc, 32'd44);
    step();
    chk("redir_next_pc", bus.id_pc, 32'd48);

    // redirect coinciding with a stall
    bus.id_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd56;
    step();
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    push_stream(32'd56);
    chkb("redir_stall_bubble", bus.id_valid, 1'b0);
    step();
    chk("redir_stall_pc", bus.id_pc, 32'd56);

    // free-run to the end of memory
    n = 0;
    while (!bus.fetch_done && n < 60) begin
      step();
      n++;
    end
    chkb("reach_done", bus.fetch_done, 1'b1);
    chk("last_pc", bus.id_pc, 32'd124);
    chkb("last_valid", bus.id_valid, 1'b1);
    step();
    chkb("done_valid_clear", bus.id_valid, 1'b0);
    chkb("done_sticky", bus.fetch_done, 1'b1);
    chk("done_stream_empty", 32'(exp_q.size()), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd60;
    step();
    bus.redirect_valid = 1'b0;
    push_stream(32'd60);
    chkb("resume_not_done", bus.fetch_done, 1'b0);
    step();
    chk("resume_pc", bus.id_pc, 32'd60);

    // misaligned redirect to 46
    bus.redirect_valid = 1'b1;
    bus.redirect_target = 32'd46;
    step();
`ifdef FETCH_ALIGN_CHECK_EN
    exp_q.delete();
    chkb("fault_flag", bus.fetch_fault, 1'b1);
    chkb("fault_valid", bus.id_valid, 1'b0);
    chk("fault_pc_frozen", bus.imem_addr, 32'd64);
    bus.redirect_target = 32'd8;
    repeat (4) begin
      step();
      chkb("fault_hold_valid", bus.id_valid, 1'b0);
      chkb("fault_hold_flag", bus.fetch_fault, 1'b1);
    end
    bus.redirect_valid = 1'b0;
`else
    bus.redirect_valid = 1'b0;
    push_stream(32'd46);
    chkb("misalign_bubble", bus.id_valid, 1'b0);
    chkb("misalign_no_fault", bus.fetch_fault, 1'b0);
    step();
    chk("misalign_pc", bus.id_pc, 32'd44);
`endif

    // reset mid-stream
    step();
    reset = 1'b1;
    #1;
    chkb("async_rst_valid", bus.id_valid, 1'b0);
    chk("async_rst_addr", bus.imem_addr, 32'd0);
    chkb("async_rst_fault", bus.fetch_fault, 1'b0);
    push_stream(32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_rst_pc", bus.id_pc, 32'd0);
    chkb("post_rst_valid", bus.id_valid, 1'b1);

    // random stalls and redirects
    for (int i = 0; i < 600; i++) begin
      bus.id_ready = ($urandom_range(3) != 0);
      rv = ($urandom_range(9) == 0);
`ifdef FETCH_ALIGN_CHECK_EN
      rt = 32'($urandom_range(35)) << 2;
`else
      rt = 32'($urandom_range(143));
`endif
      bus.redirect_valid = rv;
      bus.redirect_target = rt;
      step();
      if (rv) begin
        push_stream(rt);
        chkb("rand_bubble", bus.id_valid, 1'b0);
      end
    end
    bus.redirect_valid = 1'b0;
    bus.id_ready = 1'b1;
    repeat (45) step();
    chk("drain_stream_empty", 32'(exp_q.size()), 32'd0);
    chkb("drain_done", bus.fetch_done, 1'b1);
    chkb("drain_valid", bus.id_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-issue RV32 core. Holds the program counter and drives the byte address into the instruction memory (combinational read, word at `mem[PC]`). Registers the returned word with its PC into the IF/ID register under a valid/ready handshake to decode. Applies branch/jump redirects from execute and stops cleanly at the end of instruction memory.

## Interface
- `RESET_PC`, 32'd0, PC loaded by reset.
- `ADDR_LIMIT`, 32'd128, exclusive upper bound of fetchable byte addresses. Must be a multiple of 4.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `imem_addr`  out  32  byte address to instruction memory; equals internal `pc`.
- `imem_data`  in  32  instruction word returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  execute requests a taken branch/jal/jalr this cycle.
- `redirect_target`  in  32  byte target of the redirect.
- `id_ready`  in  1  decode accepts the IF/ID register this cycle.
- `id_valid`  out  1  IF/ID register holds a live instruction.
- `id_instr`  out  32  fetched instruction.
- `id_pc`  out  32  address of `id_instr`.
- `id_pc_plus4`  out  32  `id_pc + 4`, used as link value by jal/jalr.
- `fetch_done`  out  1  `pc >= ADDR_LIMIT`; no further fetch issued.
- `fetch_fault`  out  1  misaligned redirect trapped (only with the macro; otherwise tied 0).

## Operation
- States: RUN, DONE, FAULT. Reset gives state RUN, `pc = RESET_PC`, `id_valid = 0`, `id_instr = 0`, `id_pc = 0`, `id_pc_plus4 = 4`, `fetch_done = 0`, `fetch_fault = 0`.
- Load condition is `load = !id_valid || id_ready`.
- RUN, no redirect, load=1:
  - IF/ID register gets `{imem_data, pc, pc+4}`; `id_valid = 1`.
  - `pc += 4`.
  - If the new `pc >= ADDR_LIMIT`, go to DONE.
- RUN, no redirect, load=0 (stall): `pc` and the IF/ID register hold; `imem_addr` stays stable.
- DONE:
  - No capture. `id_valid` clears when `id_ready` is 1.
  - `fetch_done = 1`, combinational from state.
- Redirect has priority over everything except reset, in any state except FAULT:
  - `pc = redirect_target`.
  - `id_valid = 0` (flush), regardless of `id_ready`.
  - Any capture in that cycle is discarded.
  - Next state is RUN if target < ADDR_LIMIT, else DONE.
- Zero words (32'b0) are passed through as ordinary instructions (nop). No decoding happens here.
- PC arithmetic is 32-bit modulo. Overflow past 0xFFFFFFFC wraps but is unreachable while ADDR_LIMIT < 2^32.

## Timing
- Fetch latency is 1 cycle: `pc` is presented in cycle n, and `id_valid`/`id_pc = pc` appear after edge n.
- Sustained throughput is 1 instruction/cycle while `id_ready = 1`.
- Redirect penalty is exactly 1 bubble cycle:
  - Redirect asserted in cycle n → `id_valid = 0` in n+1.
  - Target instruction is valid in n+2 if `id_ready` is 1.
- A stall followed by release resumes with no skipped or duplicated PC.
- Asserting `reset` mid-stall or mid-redirect clears everything within the same cycle (asynchronous). The first post-reset capture occurs at the first rising edge after deassertion.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_target[1:0] != 0` sends the FSM to FAULT: `fetch_fault = 1`, `id_valid = 0`, `pc` frozen at the old value.
  - FAULT ignores all inputs until reset.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - Targets are force-aligned: `pc = {redirect_target[31:2], 2'b00}`.
  - `fetch_fault` is constant 0 and the FAULT state is not built.

## Test plan
- Reset release, `id_ready = 1`, memory preloaded with the standard program → edge 1: `id_pc = 0`, `id_instr = 0`. Edge 2: `id_pc = 4`, `id_instr = 32'h00101083`, `id_pc_plus4 = 8`.
- `id_ready = 0` for 3 cycles while `id_pc = 8` → `id_pc` held at 8, `imem_addr` held at 12. After release: `id_pc = 12`, then 16.
- `redirect_valid = 1`, target 44, while `id_pc = 36` → next cycle `id_valid = 0`, then `id_pc = 44`, then 48. Address 40 is never presented to decode.
- Redirect to 56 in the same cycle as `id_ready = 0` → flush wins: `id_valid = 0`, then `id_pc = 56`.
- Free-run with ADDR_LIMIT = 128 → last valid `id_pc = 124`, then `fetch_done = 1` and `id_valid = 0` after accept. A redirect to 60 resumes RUN with `id_pc = 60`.
- Redirect to 46:
  - with `FETCH_ALIGN_CHECK_EN`: `fetch_fault = 1`, no further `id_valid` until reset.
  - without it: `id_pc = 44`.
- Reset asserted mid-stream → `id_valid` drops immediately; after release, fetch restarts at `id_pc = 0`.
